// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_rf_pkg : shared widths and types for the RI5CY register-file writeback
// Revision     : 1.0
// ----------------------------------------------------------------------------
package riscv_rf_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  typedef enum logic [0:0] {
    RR_ALU = 1'b0,
    RR_MUL = 1'b1
  } rr_sel_e;

endpackage
`default_nettype wire

// File: rtl/riscv_rf_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_rf_scoreboard : pending-destination tracker with hazard/stall lookups
// Revision            : 1.0
// ----------------------------------------------------------------------------
module riscv_rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = riscv_rf_pkg::ADDR_WIDTH,
  parameter int NUM_WORDS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  input  logic                  clr_a_valid_i,
  input  logic [ADDR_WIDTH-1:0] clr_a_addr_i,
  input  logic                  clr_b_valid_i,
  input  logic [ADDR_WIDTH-1:0] clr_b_addr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o,
  output logic                  hazard_c_o,
  output logic                  stall_o
);

  // Bit 0 is held at zero so x0 can never look pending.
  logic [NUM_WORDS-1:0] r_pending;
  logic [NUM_WORDS-1:0] w_pending_nxt;
  logic                 w_set;

  assign stall_o    = r_pending[issue_rd_i];
  assign hazard_a_o = r_pending[raddr_a_i];
  assign hazard_b_o = r_pending[raddr_b_i];
  assign hazard_c_o = r_pending[raddr_c_i];

  assign w_set = issue_valid_i & ~stall_o & (issue_rd_i != '0);

  // Set is applied after the clears so a same-cycle set on a committing register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (clr_a_valid_i) w_pending_nxt[clr_a_addr_i] = 1'b0;
    if (clr_b_valid_i) w_pending_nxt[clr_b_addr_i] = 1'b0;
    if (w_set)         w_pending_nxt[issue_rd_i]   = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/riscv_rf_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_rf_wb_arbiter : ALU/MULT/LSU writeback scheduler for the 2W/3R RF
// Revision            : 1.0
// ----------------------------------------------------------------------------
module riscv_rf_wb_arbiter
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = riscv_rf_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = riscv_rf_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  issue_stall_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o,
  output logic                  hazard_c_o,
  input  logic                  alu_req_i,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  output logic                  alu_gnt_o,
  input  logic                  mul_req_i,
  input  logic [ADDR_WIDTH-1:0] mul_waddr_i,
  input  logic [DATA_WIDTH-1:0] mul_wdata_i,
  output logic                  mul_gnt_o,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o
);

  rr_sel_e               r_rr_ptr;
  rr_sel_e               w_rr_ptr_nxt;
  logic                  w_pick_alu;
  logic                  w_cand_valid;
  logic [ADDR_WIDTH-1:0] w_cand_waddr;
  logic [DATA_WIDTH-1:0] w_cand_wdata;
  logic                  w_collide;
  logic                  w_gnt_a;

  // Port A candidate selection, LSU collision hold-off and pointer update.
  always_comb begin
    w_pick_alu   = alu_req_i & (~mul_req_i | (r_rr_ptr == RR_ALU));
    w_cand_valid = alu_req_i | mul_req_i;
    w_cand_waddr = w_pick_alu ? alu_waddr_i : mul_waddr_i;
    w_cand_wdata = w_pick_alu ? alu_wdata_i : mul_wdata_i;
    // The RF gives port B priority on equal addresses, so port A must wait.
    w_collide    = lsu_valid_i & (lsu_waddr_i != '0) & (w_cand_waddr == lsu_waddr_i);
    w_gnt_a      = w_cand_valid & ~w_collide;
    alu_gnt_o    = w_gnt_a & w_pick_alu;
    mul_gnt_o    = w_gnt_a & ~w_pick_alu;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_gnt_a) w_rr_ptr_nxt = w_pick_alu ? RR_MUL : RR_ALU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= RR_ALU;
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
    end else begin
      r_rr_ptr  <= w_rr_ptr_nxt;
      we_a_o    <= w_gnt_a & (w_cand_waddr != '0);
      waddr_a_o <= w_gnt_a ? w_cand_waddr : '0;
      wdata_a_o <= w_gnt_a ? w_cand_wdata : '0;
      we_b_o    <= lsu_valid_i & (lsu_waddr_i != '0);
      waddr_b_o <= lsu_valid_i ? lsu_waddr_i : '0;
      wdata_b_o <= lsu_valid_i ? lsu_wdata_i : '0;
    end
  end

  riscv_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WORDS  (2 ** ADDR_WIDTH)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .clr_a_valid_i (we_a_o),
    .clr_a_addr_i  (waddr_a_o),
    .clr_b_valid_i (we_b_o),
    .clr_b_addr_i  (waddr_b_o),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .raddr_c_i     (raddr_c_i),
    .hazard_a_o    (hazard_a_o),
    .hazard_b_o    (hazard_b_o),
    .hazard_c_o    (hazard_c_o),
    .stall_o       (issue_stall_o)
  );

endmodule
`default_nettype wire
